// File: rtl/audio_recorder.sv
// Left-channel I2S capture from the WM8731 ADC into sequential SRAM writes, clocked by codec BCLK.
// Optional: define AUDREC_PEAK_EN to add the o_peak magnitude tracker.
module audio_recorder #(
    parameter int                ADDR_W   = 20,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init_done,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_lrc,
    input  logic              i_data,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_wen,
    output logic [ADDR_W-1:0] o_len,
    output logic              o_full,
    output logic              o_busy
`ifdef AUDREC_PEAK_EN
    ,
    output logic [DATA_W-1:0] o_peak
`endif
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SHIFT,
        WRITE,
        PAUSE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              init_latch;
    logic              lrc_prev;
    logic              pause_pend;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] shift_reg;
    logic [DATA_W-1:0] sample;
    logic              left_edge;
    logic              last_bit;
    logic              at_max;
    logic              start_rec;
    logic              capture;

    assign left_edge = lrc_prev & ~i_lrc;
    assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
    assign at_max    = (o_address == MAX_ADDR);
    assign sample    = {shift_reg, i_data};
    assign o_busy    = (state == WAIT) || (state == SHIFT) || (state == WRITE);
    assign capture   = (state == SHIFT) && (state_next == WRITE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stop outranks pause, which outranks start, in every state.
    always_comb begin
        state_next = state;
        start_rec  = 1'b0;
        case (state)
            IDLE: begin
                if (!i_stop && !i_pause && i_start && init_latch) begin
                    state_next = WAIT;
                    start_rec  = 1'b1;
                end
            end
            WAIT: begin
                if (i_stop) begin
                    state_next = IDLE;
                end else if (i_pause) begin
                    state_next = PAUSE;
                end else if (left_edge) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (i_stop) begin
                    state_next = IDLE;
                end else if (last_bit) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (at_max || i_stop) begin
                    state_next = IDLE;
                end else if (pause_pend || i_pause) begin
                    state_next = PAUSE;
                end else begin
                    state_next = WAIT;
                end
            end
            PAUSE: begin
                if (i_stop) begin
                    state_next = IDLE;
                end else if (!i_pause && i_start) begin
                    state_next = WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The write strobe is registered on the last bit so it is high exactly while in WRITE.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            init_latch <= 1'b0;
            lrc_prev   <= 1'b1;
            pause_pend <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            o_address  <= '0;
            o_data     <= '0;
            o_wen      <= 1'b0;
            o_len      <= '0;
            o_full     <= 1'b0;
        end else begin
            lrc_prev <= i_lrc;
            o_wen    <= capture;
            if (i_init_done) begin
                init_latch <= 1'b1;
            end
            if (state == SHIFT) begin
                shift_reg  <= sample[DATA_W-2:0];
                bit_cnt    <= bit_cnt + CNT_W'(1);
                pause_pend <= pause_pend | i_pause;
            end else begin
                bit_cnt    <= '0;
                pause_pend <= 1'b0;
            end
            if (capture) begin
                o_data <= sample;
                o_len  <= o_address + ADDR_W'(1);
            end
            if (start_rec) begin
                o_address <= '0;
                o_len     <= '0;
                o_full    <= 1'b0;
            end else if (state == WRITE) begin
                if (at_max) begin
                    o_full <= 1'b1;
                end else begin
                    o_address <= o_address + ADDR_W'(1);
                end
            end
        end
    end

`ifdef AUDREC_PEAK_EN
    logic [DATA_W-1:0] sample_mag;

    // Negating the most negative code overflows back to itself, so it saturates.
    always_comb begin
        sample_mag = sample;
        if (sample[DATA_W-1]) begin
            sample_mag = -sample;
            if (sample_mag[DATA_W-1]) begin
                sample_mag = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_peak <= '0;
        end else if (start_rec) begin
            o_peak <= '0;
        end else if (capture && (sample_mag > o_peak)) begin
            o_peak <= sample_mag;
        end
    end
`endif

endmodule
